// File: rtl/router_arbiter_pkg.sv
// Shared router arbiter definitions: one-hot state encodings and rotating-priority winner pick.
// Input and output arbiters both import this package so that their encodings stay identical.
package router_arbiter_pkg;

  localparam int CREDIT_MAX_DEFAULT = 3;
  localparam int NUM_PORTS          = 5;

  // Bit i+1 of the state marks port i (N=0, E=1, W=2, S=3, L=4) as the last holder.
  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    NORTH = 6'b000010,
    EAST  = 6'b000100,
    WEST  = 6'b001000,
    SOUTH = 6'b010000,
    LOCAL = 6'b100000
  } state_t;

  // req/return bit order: {L, S, W, E, N}. The current holder keeps top priority.
  function automatic logic [NUM_PORTS-1:0] pick_winner(input state_t st,
                                                       input logic [NUM_PORTS-1:0] req);
    logic [2:0] start;
    logic [3:0] sum;
    logic [2:0] idx;
    logic       found;
    pick_winner = '0;
    found       = 1'b0;
    case (st)
      IDLE, NORTH: start = 3'd0;
      EAST:        start = 3'd1;
      WEST:        start = 3'd2;
      SOUTH:       start = 3'd3;
      default:     start = 3'd4;
    endcase
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, start} + 4'(i);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!found && req[idx]) begin
        pick_winner[idx] = 1'b1;
        found            = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit tracker: dec on grant, inc on returned credit, saturating at CREDIT_MAX.
// Registered count; a return at full credit sets a sticky overflow flag cleared only by reset.
module credit_counter #(
  parameter int CREDIT_MAX = 3,
  parameter int CREDIT_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  output logic [CREDIT_W-1:0] count,
  output logic                nonzero,
  output logic                overflow
);

  localparam logic [CREDIT_W-1:0] MAX_CNT = CREDIT_W'(CREDIT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= MAX_CNT;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count == MAX_CNT) overflow <= 1'b1;
      else                  count    <= count + CREDIT_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CREDIT_W'(1);
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/arbiter_out_credit.sv
// Output-port arbiter: rotating-priority pick among five inputs, zero-cycle grant gated by credit.
// No credit means no grant and no priority rotation; requests simply wait for a credit return.
module arbiter_out_credit
  import router_arbiter_pkg::*;
#(
  parameter int CREDIT_MAX = CREDIT_MAX_DEFAULT,
  parameter int CREDIT_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                X_N_Y,
  input  logic                X_E_Y,
  input  logic                X_W_Y,
  input  logic                X_S_Y,
  input  logic                X_L_Y,
  input  logic                credit_in,
  output logic                grant_Y_N,
  output logic                grant_Y_E,
  output logic                grant_Y_W,
  output logic                grant_Y_S,
  output logic                grant_Y_L,
  output logic [CREDIT_W-1:0] credit_counter_out,
  output logic                credit_overflow
);

  state_t                 state;
  state_t                 state_nxt;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   winner;
  logic [NUM_PORTS-1:0]   grant_vec;
  logic                   credit_ok;
  logic                   any_grant;

  assign req = {X_L_Y, X_S_Y, X_W_Y, X_E_Y, X_N_Y};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    grant_vec = '0;
    state_nxt = state;
    winner    = pick_winner(state, req);
    if (credit_ok && !reset && (winner != '0)) begin
      grant_vec = winner;
      // Winner bit i maps onto state bit i+1 by construction of the encodings.
      state_nxt = state_t'({winner, 1'b0});
    end
  end

  assign any_grant = |grant_vec;
  assign {grant_Y_L, grant_Y_S, grant_Y_W, grant_Y_E, grant_Y_N} = grant_vec;

  credit_counter #(
    .CREDIT_MAX (CREDIT_MAX),
    .CREDIT_W   (CREDIT_W)
  ) u_credit (
    .clk      (clk),
    .reset    (reset),
    .inc      (credit_in),
    .dec      (any_grant),
    .count    (credit_counter_out),
    .nonzero  (credit_ok),
    .overflow (credit_overflow)
  );

endmodule

// File: tb/tb_arbiter_out_credit.sv
// Bench for arbiter_out_credit: table of per-cycle vectors with hand-derived expectations,
// plus hand sequences for reset (including asynchronous assertion mid-cycle).
module tb_arbiter_out_credit;

  localparam logic [4:0] RQ_0 = 5'b00000;
  localparam logic [4:0] RQ_N = 5'b00001;
  localparam logic [4:0] RQ_E = 5'b00010;
  localparam logic [4:0] RQ_W = 5'b00100;
  localparam logic [4:0] RQ_S = 5'b01000;
  localparam logic [4:0] RQ_L = 5'b10000;
  localparam logic [4:0] RQ_A = 5'b11111;
  localparam int NV = 23;

  typedef struct packed {
    logic [4:0] req;
    logic       cin;
    logic [4:0] gnt;
    logic [1:0] cnt;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req;
  logic       credit_in;
  logic       grant_Y_N, grant_Y_E, grant_Y_W, grant_Y_S, grant_Y_L;
  logic [1:0] credit_counter_out;
  logic       credit_overflow;
  logic [4:0] gnt;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[NV];
  vec_t exp_q[$];
  vec_t e;

  always #5 clk = ~clk;

  assign gnt = {grant_Y_L, grant_Y_S, grant_Y_W, grant_Y_E, grant_Y_N};

  arbiter_out_credit #(.CREDIT_MAX(3), .CREDIT_W(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .X_N_Y              (req[0]),
    .X_E_Y              (req[1]),
    .X_W_Y              (req[2]),
    .X_S_Y              (req[3]),
    .X_L_Y              (req[4]),
    .credit_in          (credit_in),
    .grant_Y_N          (grant_Y_N),
    .grant_Y_E          (grant_Y_E),
    .grant_Y_W          (grant_Y_W),
    .grant_Y_S          (grant_Y_S),
    .grant_Y_L          (grant_Y_L),
    .credit_counter_out (credit_counter_out),
    .credit_overflow    (credit_overflow)
  );

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Expected grant/count/overflow are the values visible during that cycle.
    vecs[0]  = '{RQ_E, 1'b0, RQ_E, 2'd3, 1'b0};
    vecs[1]  = '{RQ_E, 1'b0, RQ_E, 2'd2, 1'b0};
    vecs[2]  = '{RQ_E, 1'b0, RQ_E, 2'd1, 1'b0};
    vecs[3]  = '{RQ_E, 1'b0, RQ_0, 2'd0, 1'b0};
    vecs[4]  = '{RQ_N, 1'b1, RQ_0, 2'd0, 1'b0};
    vecs[5]  = '{RQ_N, 1'b0, RQ_N, 2'd1, 1'b0};
    vecs[6]  = '{RQ_N, 1'b0, RQ_0, 2'd0, 1'b0};
    vecs[7]  = '{RQ_0, 1'b1, RQ_0, 2'd0, 1'b0};
    vecs[8]  = '{RQ_0, 1'b1, RQ_0, 2'd1, 1'b0};
    vecs[9]  = '{RQ_0, 1'b1, RQ_0, 2'd2, 1'b0};
    vecs[10] = '{RQ_E, 1'b1, RQ_E, 2'd3, 1'b0};
    vecs[11] = '{RQ_N | RQ_W, 1'b1, RQ_W, 2'd3, 1'b0};
    vecs[12] = '{RQ_N, 1'b0, RQ_N, 2'd3, 1'b0};
    vecs[13] = '{RQ_S, 1'b1, RQ_S, 2'd2, 1'b0};
    vecs[14] = '{RQ_A, 1'b0, RQ_S, 2'd2, 1'b0};
    vecs[15] = '{RQ_L | RQ_N | RQ_E | RQ_W, 1'b1, RQ_L, 2'd1, 1'b0};
    vecs[16] = '{RQ_N | RQ_E | RQ_W | RQ_S, 1'b1, RQ_N, 2'd1, 1'b0};
    vecs[17] = '{RQ_0, 1'b1, RQ_0, 2'd1, 1'b0};
    vecs[18] = '{RQ_0, 1'b1, RQ_0, 2'd2, 1'b0};
    vecs[19] = '{RQ_0, 1'b1, RQ_0, 2'd3, 1'b0};
    vecs[20] = '{RQ_0, 1'b0, RQ_0, 2'd3, 1'b1};
    vecs[21] = '{RQ_E, 1'b0, RQ_E, 2'd3, 1'b1};
    vecs[22] = '{RQ_0, 1'b1, RQ_0, 2'd2, 1'b1};

    // Reset: grants gated even with every request up; credit pulses during reset are dropped.
    reset     = 1'b1;
    req       = RQ_A;
    credit_in = 1'b0;
    #2;
    check("rst_count", 0, int'(credit_counter_out), 3);
    check("rst_ovf",   0, int'(credit_overflow), 0);
    check("rst_grant", 0, int'(gnt), 0);
    credit_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req       = RQ_0;
    credit_in = 1'b0;
    #1;
    check("rst_rel_count", 0, int'(credit_counter_out), 3);
    check("rst_rel_ovf",   0, int'(credit_overflow), 0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      req       = vecs[i].req;
      credit_in = vecs[i].cin;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check("grant", i, int'(gnt), int'(e.gnt));
      check("count", i, int'(credit_counter_out), int'(e.cnt));
      check("ovf",   i, int'(credit_overflow), int'(e.ovf));
    end

    // Take one credit, then assert reset between clock edges.
    @(posedge clk);
    #1;
    req       = RQ_E;
    credit_in = 1'b0;
    @(negedge clk);
    check("pre_grant", 0, int'(gnt), int'(RQ_E));
    check("pre_count", 0, int'(credit_counter_out), 3);
    @(posedge clk);
    #1;
    req       = RQ_A;
    credit_in = 1'b1;
    #2;
    check("pre_rst_count", 0, int'(credit_counter_out), 2);
    check("pre_rst_ovf",   0, int'(credit_overflow), 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_count", 0, int'(credit_counter_out), 3);
    check("async_ovf",   0, int'(credit_overflow), 0);
    check("async_grant", 0, int'(gnt), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    credit_in = 1'b0;
    reset     = 1'b0;
    #1;
    check("post_rst_count", 0, int'(credit_counter_out), 3);
    check("post_rst_ovf",   0, int'(credit_overflow), 0);
    check("idle_prio",      0, int'(gnt), int'(RQ_N));
    @(posedge clk);
    #1;
    req = RQ_0;
    @(negedge clk);
    check("post_grant_count", 0, int'(credit_counter_out), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
